// File: rtl/vga_pkg.sv
// Shared VGA types and helpers: RGB332/RGB888 pixel formats and default framebuffer geometry.
package vga_pkg;

    localparam int unsigned FB_WIDTH_DEF   = 320;
    localparam int unsigned SCALE_LOG2_DEF = 1;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    // Bit replication so that full-scale codes map to 8'hFF and zero stays zero.
    function automatic rgb24_t rgb332_expand(input rgb332_t p);
        rgb24_t c;
        c.r = {p.r, p.r, p.r[2:1]};
        c.g = {p.g, p.g, p.g[2:1]};
        c.b = {p.b, p.b, p.b, p.b};
        return c;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Clock-enable gated shift register used to keep sync/blanking aligned with fetched pixels.
module vga_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] DOUT
);

    logic [WIDTH-1:0] stages_q [DEPTH];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                stages_q[i] <= '0;
            end
        end else if (CE) begin
            stages_q[0] <= DIN;
            for (int i = 1; i < int'(DEPTH); i++) begin
                stages_q[i] <= stages_q[i-1];
            end
        end
    end

    assign DOUT = stages_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_fetch.sv
// Framebuffer address generation with integer pixel replication, RGB332 expansion and
// sync/blank re-alignment to the returned colour.
module vga_pixel_fetch
    import vga_pkg::*;
#(
    parameter int unsigned FB_WIDTH   = FB_WIDTH_DEF,
    parameter int unsigned ADDR_W     = 17,
    parameter int unsigned SCALE_LOG2 = SCALE_LOG2_DEF,
    parameter int unsigned RD_LAT     = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PIX_CE,
    input  logic              H_ENA,
    input  logic              V_ENA,
    input  logic [9:0]        H_POS,
    input  logic              HS_IN,
    input  logic              VS_IN,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic              MEM_RE,
    input  logic [7:0]        MEM_RDATA,
    output logic [7:0]        R,
    output logic [7:0]        G,
    output logic [7:0]        B,
    output logic              HS_OUT,
    output logic              VS_OUT,
    output logic              BLANK_N
);

    localparam int unsigned L     = RD_LAT + 2;
    localparam int unsigned REP_W = (SCALE_LOG2 > 0) ? SCALE_LOG2 : 1;
    localparam logic [REP_W-1:0]  REP_MAX  = REP_W'((1 << SCALE_LOG2) - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(FB_WIDTH);

    logic              active;
    logic              h_fall;
    logic              h_ena_q;
    logic [REP_W-1:0]  rep_q, rep_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_re_q;
    rgb24_t            rgb_q;
    logic [2:0]        dly_out;

    assign active = H_ENA & V_ENA;
    assign h_fall = h_ena_q & ~H_ENA;

    // V_ENA low dominates any coincident H_ENA fall so every frame starts at row 0.
    always_comb begin
        row_base_d = row_base_q;
        rep_d      = rep_q;
        if (!V_ENA) begin
            row_base_d = '0;
            rep_d      = '0;
        end else if (h_fall) begin
            if (rep_q == REP_MAX) begin
                rep_d      = '0;
                row_base_d = row_base_q + ROW_STEP;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end
    end

    assign addr_d = row_base_q + ADDR_W'(H_POS >> SCALE_LOG2);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            h_ena_q    <= 1'b0;
            rep_q      <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            mem_re_q   <= 1'b0;
            rgb_q      <= '0;
        end else if (PIX_CE) begin
            h_ena_q    <= H_ENA;
            rep_q      <= rep_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            mem_re_q   <= active;
            rgb_q      <= rgb332_expand(rgb332_t'(MEM_RDATA));
        end
    end

    assign MEM_ADDR = addr_q;
    assign MEM_RE   = mem_re_q & PIX_CE;

    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (L)
    ) u_sync_dly (
        .CLK  (CLK),
        .RST  (RST),
        .CE   (PIX_CE),
        .DIN  ({HS_IN, VS_IN, active}),
        .DOUT (dly_out)
    );

    assign HS_OUT  = dly_out[2];
    assign VS_OUT  = dly_out[1];
    assign BLANK_N = dly_out[0];

    // Colour register is unconditional; blanking is applied from the aligned BLANK_N register.
    assign R = BLANK_N ? rgb_q.r : 8'h00;
    assign G = BLANK_N ? rgb_q.g : 8'h00;
    assign B = BLANK_N ? rgb_q.b : 8'h00;

endmodule

// File: tb/tb_vga_pixel_fetch.sv
// Directed self-checking bench for vga_pixel_fetch with default parameters.
module tb_vga_pixel_fetch;

    logic        CLK = 1'b0;
    logic        RST;
    logic        PIX_CE;
    logic        H_ENA;
    logic        V_ENA;
    logic [9:0]  H_POS;
    logic        HS_IN;
    logic        VS_IN;
    logic [16:0] MEM_ADDR;
    logic        MEM_RE;
    logic [7:0]  MEM_RDATA;
    logic [7:0]  R;
    logic [7:0]  G;
    logic [7:0]  B;
    logic        HS_OUT;
    logic        VS_OUT;
    logic        BLANK_N;

    int n_checks = 0;
    int n_fail   = 0;

    vga_pixel_fetch dut (
        .CLK       (CLK),
        .RST       (RST),
        .PIX_CE    (PIX_CE),
        .H_ENA     (H_ENA),
        .V_ENA     (V_ENA),
        .H_POS     (H_POS),
        .HS_IN     (HS_IN),
        .VS_IN     (VS_IN),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_RE    (MEM_RE),
        .MEM_RDATA (MEM_RDATA),
        .R         (R),
        .G         (G),
        .B         (B),
        .HS_OUT    (HS_OUT),
        .VS_OUT    (VS_OUT),
        .BLANK_N   (BLANK_N)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST = 1'b0; PIX_CE = 1'b1; H_ENA = 1'b0; V_ENA = 1'b0; H_POS = '0;
        HS_IN = 1'b0; VS_IN = 1'b0; MEM_RDATA = '0;

        // Reset held with random activity
        for (int i = 0; i < 6; i++) begin
            H_ENA = 1'($urandom); V_ENA = 1'($urandom); H_POS = 10'($urandom);
            HS_IN = 1'($urandom); VS_IN = 1'($urandom); MEM_RDATA = 8'($urandom);
            PIX_CE = 1'($urandom);
            step();
        end
        chk("rst_addr", 32'(MEM_ADDR), 0);
        chk("rst_re", 32'(MEM_RE), 0);
        chk("rst_r", 32'(R), 0);
        chk("rst_g", 32'(G), 0);
        chk("rst_b", 32'(B), 0);
        chk("rst_hs", 32'(HS_OUT), 0);
        chk("rst_vs", 32'(VS_OUT), 0);
        chk("rst_blank", 32'(BLANK_N), 0);

        // Release and first-line fetch / colour latency
        PIX_CE = 1'b1; H_ENA = 1'b1; V_ENA = 1'b1; H_POS = 10'd0;
        HS_IN = 1'b0; VS_IN = 1'b0; MEM_RDATA = 8'hE0; RST = 1'b1;
        step();
        chk("rel_addr", 32'(MEM_ADDR), 0);
        chk("rel_re", 32'(MEM_RE), 1);
        chk("rel_blank1", 32'(BLANK_N), 0);
        H_POS = 10'd5;
        step();
        chk("pos5_addr", 32'(MEM_ADDR), 2);
        chk("rel_blank2", 32'(BLANK_N), 0);
        step();
        chk("rel_blank3", 32'(BLANK_N), 0);
        chk("rel_r3", 32'(R), 0);
        step();
        chk("lat4_blank", 32'(BLANK_N), 1);
        chk("e0_r", 32'(R), 8'hFF);
        chk("e0_g", 32'(G), 8'h00);
        chk("e0_b", 32'(B), 8'h00);
        MEM_RDATA = 8'h1F;
        step();
        chk("1f_r", 32'(R), 8'h00);
        chk("1f_g", 32'(G), 8'hFF);
        chk("1f_b", 32'(B), 8'hFF);

        // Line replication and row stepping
        H_ENA = 1'b0; step(); step();
        H_ENA = 1'b1; H_POS = 10'd0; step();
        chk("line2_addr", 32'(MEM_ADDR), 0);
        H_ENA = 1'b0; step();
        H_ENA = 1'b1; step();
        chk("line3_addr", 32'(MEM_ADDR), 320);
        H_POS = 10'd7; step();
        chk("line3_pos7", 32'(MEM_ADDR), 323);
        H_ENA = 1'b0; step();
        H_ENA = 1'b1; H_POS = 10'd0; step();
        chk("line4_addr", 32'(MEM_ADDR), 320);
        H_ENA = 1'b0; step();
        H_ENA = 1'b1; step();
        chk("line5_addr", 32'(MEM_ADDR), 640);
        V_ENA = 1'b0; H_ENA = 1'b0; step();
        chk("vblank_re", 32'(MEM_RE), 0);
        step();
        V_ENA = 1'b1; H_ENA = 1'b1; step();
        chk("frame2_addr", 32'(MEM_ADDR), 0);

        // Sync pulses during blanking
        H_ENA = 1'b0; MEM_RDATA = 8'hFF;
        repeat (5) step();
        chk("blank_flush", 32'(BLANK_N), 0);
        chk("blank_r_ff", 32'(R), 0);
        HS_IN = 1'b1; VS_IN = 1'b1; step();
        HS_IN = 1'b0; step();
        VS_IN = 1'b0; step();
        chk("hs_early", 32'(HS_OUT), 0);
        step();
        chk("hs_on", 32'(HS_OUT), 1);
        chk("vs_on", 32'(VS_OUT), 1);
        chk("hs_blank_r", 32'(R), 0);
        chk("hs_blank_g", 32'(G), 0);
        chk("hs_blank_n", 32'(BLANK_N), 0);
        step();
        chk("hs_off", 32'(HS_OUT), 0);
        chk("vs_still", 32'(VS_OUT), 1);
        step();
        chk("vs_off", 32'(VS_OUT), 0);

        // Clock-enable gaps
        V_ENA = 1'b0; step();
        V_ENA = 1'b1; H_ENA = 1'b1; H_POS = 10'd10; MEM_RDATA = 8'h1F; step();
        chk("ce_addr1", 32'(MEM_ADDR), 5);
        chk("ce_re1", 32'(MEM_RE), 1);
        PIX_CE = 1'b0; H_POS = 10'd20; step();
        chk("ce_hold_addr", 32'(MEM_ADDR), 5);
        chk("ce_hold_re", 32'(MEM_RE), 0);
        chk("ce_hold_blank1", 32'(BLANK_N), 0);
        PIX_CE = 1'b1; step();
        chk("ce_addr2", 32'(MEM_ADDR), 10);
        chk("ce_re2", 32'(MEM_RE), 1);
        PIX_CE = 1'b0; step();
        chk("ce_hold_addr2", 32'(MEM_ADDR), 10);
        chk("ce_hold_re2", 32'(MEM_RE), 0);
        PIX_CE = 1'b1; step();
        chk("ce_blank3", 32'(BLANK_N), 0);
        PIX_CE = 1'b0; step();
        chk("ce_hold_blank3", 32'(BLANK_N), 0);
        PIX_CE = 1'b1; step();
        chk("ce_blank4", 32'(BLANK_N), 1);
        chk("ce_r4", 32'(R), 8'h00);
        chk("ce_g4", 32'(G), 8'hFF);
        chk("ce_b4", 32'(B), 8'hFF);
        PIX_CE = 1'b0; MEM_RDATA = 8'hE0; step();
        chk("ce_hold_blank4", 32'(BLANK_N), 1);
        chk("ce_hold_g4", 32'(G), 8'hFF);
        PIX_CE = 1'b1;

        // Address wrap modulo 2^17
        H_ENA = 1'b0; V_ENA = 1'b0; step();
        V_ENA = 1'b1;
        for (int i = 0; i < 818; i++) begin
            H_ENA = 1'b1; step();
            H_ENA = 1'b0; step();
        end
        H_ENA = 1'b1; H_POS = 10'd0; step();
        chk("row409_addr", 32'(MEM_ADDR), 130880);
        H_POS = 10'd638; step();
        chk("wrap_col", 32'(MEM_ADDR), 127);
        H_ENA = 1'b0; step();
        H_ENA = 1'b1; step();
        H_ENA = 1'b0; step();
        H_ENA = 1'b1; H_POS = 10'd0; step();
        chk("wrap_row", 32'(MEM_ADDR), 128);

        // Coincident H_ENA/V_ENA fall
        H_ENA = 1'b0; step();
        H_ENA = 1'b1; step();
        chk("pre_sim_addr", 32'(MEM_ADDR), 128);
        H_ENA = 1'b0; V_ENA = 1'b0; step();
        V_ENA = 1'b1; H_ENA = 1'b1; H_POS = 10'd0; step();
        chk("sim_fall_addr", 32'(MEM_ADDR), 0);
        H_ENA = 1'b0; step();
        H_ENA = 1'b1; step();
        chk("sim_rep_cleared", 32'(MEM_ADDR), 0);
        H_ENA = 1'b0; step();
        H_ENA = 1'b1; step();
        chk("sim_next_row", 32'(MEM_ADDR), 320);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
